// File: rtl/sevenseg_scan.sv
// Four-digit common-anode 7-segment scanner: slot prescaler, frame-synchronous
// value update, anti-ghost blanking and leading-zero suppression.
module sevenseg_scan #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 64,
   parameter int DIV_W     = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [15:0] wr_data,
   input  logic        lz_en,
   output logic [3:0]  nib_out,
   input  logic [6:0]  seg_in,
   output logic [6:0]  seg_out,
   output logic [3:0]  an_out,
   output logic        frame_tick
);

   localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(SCAN_DIV - 1);

   logic [DIV_W-1:0] cnt;
   logic [1:0]       idx;
   logic [15:0]      shadow;
   logic [15:0]      disp;
   logic             pend;

   logic             slot_end;
   logic             frame_end;
   logic             in_blank;
   logic [3:0]       sup;
   logic             sup_cur;
   logic             blank;

   assign slot_end  = (cnt == CNT_LAST);
   assign frame_end = slot_end && (idx == 2'd3);

   // With no blanking window the compare would be against zero; drop it.
   generate
      if (BLANK_CYC == 0) begin : g_noblank
         assign in_blank = 1'b0;
      end else begin : g_blank
         assign in_blank = (cnt < DIV_W'(BLANK_CYC));
      end
   endgenerate

   // A digit is dark when it and every more significant digit are zero.
   assign sup[0] = 1'b0;
   assign sup[1] = lz_en & ~(|disp[15:4]);
   assign sup[2] = lz_en & ~(|disp[15:8]);
   assign sup[3] = lz_en & ~(|disp[15:12]);

   assign sup_cur = sup[idx];
   assign blank   = in_blank | sup_cur;
   assign nib_out = disp[{idx, 2'b00} +: 4];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt        <= '0;
         idx        <= 2'd0;
         shadow     <= 16'h0000;
         disp       <= 16'h0000;
         pend       <= 1'b0;
         seg_out    <= 7'h7F;
         an_out     <= 4'hF;
         frame_tick <= 1'b0;
      end else begin
         cnt        <= slot_end ? '0 : cnt + 1'b1;
         if (slot_end)
            idx <= idx + 2'd1;
         frame_tick <= frame_end;

         if (wr_en)
            shadow <= wr_data;
         // A write landing on the wrap edge keeps pend set so it loads next frame.
         if (frame_end && pend)
            disp <= shadow;
         if (wr_en)
            pend <= 1'b1;
         else if (frame_end)
            pend <= 1'b0;

         an_out  <= blank ? 4'hF : ~(4'b0001 << idx);
         seg_out <= sup_cur ? 7'h7F : seg_in;
      end
   end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan with a behavioural sevenseg_dec model.
module tb_sevenseg_scan;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [15:0] wr_data = 16'h0000;
   logic        lz_en = 1'b0;
   logic [3:0]  nib_out;
   logic [6:0]  seg_in;
   logic [6:0]  seg_out;
   logic [3:0]  an_out;
   logic        frame_tick;

   int nvec = 0;
   int nbad = 0;
   int ecount = 0;

   sevenseg_scan #(.SCAN_DIV(8), .BLANK_CYC(2), .DIV_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
      .lz_en(lz_en), .nib_out(nib_out), .seg_in(seg_in), .seg_out(seg_out),
      .an_out(an_out), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] dec(input logic [3:0] n);
      case (n)
         4'h0: dec = 7'h40;  4'h1: dec = 7'h79;  4'h2: dec = 7'h24;  4'h3: dec = 7'h30;
         4'h4: dec = 7'h19;  4'h5: dec = 7'h12;  4'h6: dec = 7'h02;  4'h7: dec = 7'h78;
         4'h8: dec = 7'h00;  4'h9: dec = 7'h10;  4'hA: dec = 7'h08;  4'hB: dec = 7'h03;
         4'hC: dec = 7'h46;  4'hD: dec = 7'h21;  4'hE: dec = 7'h06;  default: dec = 7'h0E;
      endcase
   endfunction

   assign seg_in = dec(nib_out);

   typedef struct {
      int          at;
      logic        wr;
      logic [15:0] data;
      logic        lz;
      logic [3:0]  an;
      logic [6:0]  seg;
      logic        tick;
   } vec_t;

   vec_t vq[$];

   task automatic add(input int at, input logic wr, input logic [15:0] data, input logic lz,
                      input logic [3:0] an, input logic [6:0] seg, input logic tick);
      vec_t v;
      v.at = at; v.wr = wr; v.data = data; v.lz = lz; v.an = an; v.seg = seg; v.tick = tick;
      vq.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      ecount++;
   endtask

   task automatic run_to(input int t);
      while (ecount < t) step();
   endtask

   task automatic chk(input string nm, input logic [3:0] an_e, input logic [6:0] seg_e,
                      input logic tick_e);
      nvec++;
      if (an_out !== an_e || seg_out !== seg_e || frame_tick !== tick_e) begin
         nbad++;
         $display("FAIL %s: got an=%h seg=%h tick=%b, expected an=%h seg=%h tick=%b",
                  nm, an_out, seg_out, frame_tick, an_e, seg_e, tick_e);
      end
   endtask

   task automatic chk_nib(input string nm, input logic [3:0] e);
      nvec++;
      if (nib_out !== e) begin
         nbad++;
         $display("FAIL %s: got nib=%h, expected nib=%h", nm, nib_out, e);
      end
   endtask

   task automatic write(input logic [15:0] d);
      wr_en = 1'b1;
      wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at edge %0d", ecount);
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      // Edge count k after release: state cnt=k%8, idx=(k/8)%4; outputs reflect k-1.
      add(  0, 0, 16'h0000, 0, 4'hF, 7'h7F, 0);
      add(  1, 0, 16'h0000, 0, 4'hF, 7'h40, 0);
      add(  2, 0, 16'h0000, 0, 4'hF, 7'h40, 0);
      add(  3, 0, 16'h0000, 0, 4'hE, 7'h40, 0);
      add(  9, 0, 16'h0000, 0, 4'hF, 7'h40, 0);
      add( 11, 0, 16'h0000, 0, 4'hD, 7'h40, 0);
      add( 32, 0, 16'h0000, 0, 4'h7, 7'h40, 1);
      add( 33, 0, 16'h0000, 0, 4'hF, 7'h40, 0);
      add( 63, 1, 16'hAAAA, 0, 4'h7, 7'h40, 0);
      add( 64, 1, 16'h12AF, 0, 4'h7, 7'h40, 1);
      add( 91, 0, 16'h0000, 0, 4'h7, 7'h40, 0);
      add( 99, 0, 16'h0000, 0, 4'hE, 7'h0E, 0);
      add(104, 0, 16'h0000, 0, 4'hE, 7'h0E, 0);
      add(105, 0, 16'h0000, 0, 4'hF, 7'h08, 0);
      add(107, 0, 16'h0000, 0, 4'hD, 7'h08, 0);
      add(115, 0, 16'h0000, 0, 4'hB, 7'h24, 0);
      add(123, 0, 16'h0000, 0, 4'h7, 7'h79, 0);
      add(128, 1, 16'h0050, 1, 4'h7, 7'h79, 1);
      add(163, 0, 16'h0000, 1, 4'hE, 7'h40, 0);
      add(171, 0, 16'h0000, 1, 4'hD, 7'h12, 0);
      add(179, 0, 16'h0000, 1, 4'hF, 7'h7F, 0);
      add(184, 0, 16'h0000, 1, 4'hF, 7'h7F, 0);
      add(187, 0, 16'h0000, 1, 4'hF, 7'h7F, 0);
      add(192, 0, 16'h0000, 0, 4'hF, 7'h7F, 1);
      add(203, 0, 16'h0000, 0, 4'hD, 7'h12, 0);
      add(211, 0, 16'h0000, 0, 4'hB, 7'h40, 0);
      add(220, 1, 16'h1111, 0, 4'h7, 7'h40, 0);
      add(223, 1, 16'hBEEF, 0, 4'h7, 7'h40, 0);
      add(224, 0, 16'h0000, 0, 4'h7, 7'h40, 1);
      add(227, 0, 16'h0000, 0, 4'hE, 7'h79, 0);
      add(251, 0, 16'h0000, 0, 4'h7, 7'h79, 0);
      add(256, 0, 16'h0000, 0, 4'h7, 7'h79, 1);
      add(259, 0, 16'h0000, 0, 4'hE, 7'h0E, 0);
      add(267, 0, 16'h0000, 0, 4'hD, 7'h06, 0);
      add(275, 0, 16'h0000, 0, 4'hB, 7'h06, 0);
      add(283, 0, 16'h0000, 0, 4'h7, 7'h03, 0);
      add(288, 1, 16'h7777, 0, 4'h7, 7'h03, 1);

      rst_n = 1'b0;
      step();
      step();
      chk("reset", 4'hF, 7'h7F, 1'b0);
      chk_nib("reset_nib", 4'h0);
      rst_n = 1'b1;
      ecount = 0;

      foreach (vq[i]) begin
         run_to(vq[i].at);
         chk($sformatf("vec@%0d", vq[i].at), vq[i].an, vq[i].seg, vq[i].tick);
         lz_en = vq[i].lz;
         if (vq[i].wr) write(vq[i].data);
      end

      // Reset in slot 2 while 7777 is pending: scan aborts, pending data is lost.
      run_to(306);
      chk("pre_rst_slot2", 4'hF, 7'h06, 1'b0);
      rst_n = 1'b0;
      step();
      chk("rst_mid1", 4'hF, 7'h7F, 1'b0);
      step();
      chk("rst_mid2", 4'hF, 7'h7F, 1'b0);
      rst_n = 1'b1;
      ecount = 0;
      run_to(3);
      chk("post_rst3", 4'hE, 7'h40, 1'b0);
      run_to(32);
      chk("post_rst_tick", 4'h7, 7'h40, 1'b1);
      run_to(35);
      chk("post_rst_nopend", 4'hE, 7'h40, 1'b0);
      run_to(59);
      chk("post_rst_d3", 4'h7, 7'h40, 1'b0);

      // Every nibble through slot 0, one frame per value.
      w = 67;
      for (int v = 0; v < 16; v++) begin
         run_to(w);
         write({12'h321, 4'(v)});
         run_to(w + 32);
         chk($sformatf("nib%0h_seg", v), 4'hE, dec(4'(v)), 1'b0);
         chk_nib($sformatf("nib%0h", v), 4'(v));
         w += 32;
      end

      // 0x0000 with suppression shows a lone "0" in digit 0.
      run_to(w);
      lz_en = 1'b1;
      write(16'h0000);
      run_to(w + 32);
      chk("zero_d0", 4'hE, 7'h40, 1'b0);
      run_to(w + 40);
      chk("zero_d1", 4'hF, 7'h7F, 1'b0);
      run_to(w + 56);
      chk("zero_d3", 4'hF, 7'h7F, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
